// File: rtl/mvm_result_writeback.sv
// Snapshots the MVM row results when done rises and writes them out as Avalon-MM words.
// Define WB_CHECKSUM_EN to append an XOR checksum word after the last row.
module mvm_result_writeback #(
  parameter int N          = 8,
  parameter int RES_WIDTH  = 24,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  done_in,
  input  logic [RES_WIDTH-1:0]  c_in [N],
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  output logic [3:0]            avm_byteenable,
  input  logic                  avm_waitrequest,
  output logic                  wb_done,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

`ifdef WB_CHECKSUM_EN
  localparam int WORDS = N + 1;
`else
  localparam int WORDS = N;
`endif
  // idx+1 must be representable, hence WORDS+1
  localparam int IW = $clog2(WORDS + 1);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic                    done_q;
  logic                    trig;
  logic                    accept;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           nxt;
  logic [RES_WIDTH-1:0]    cap [N];
  logic [ADDR_WIDTH-1:0]   base;
  logic [31:0]             word;
`ifdef WB_CHECKSUM_EN
  logic [RES_WIDTH-1:0]    csum;
  logic [RES_WIDTH-1:0]    csum_d;
`endif

  assign trig      = done_in & ~done_q;
  assign accept    = (state_q == WRITE) & avm_write & ~avm_waitrequest;
  assign nxt       = idx + IW'(1);
  assign wb_done   = (state_q == FINISH);
  assign busy      = (state_q == CAPTURE) | (state_q == WRITE);
  assign dbg_state = state_q;

`ifdef WB_CHECKSUM_EN
  always_comb begin
    csum_d = '0;
    for (int i = 0; i < N; i++)
      csum_d = csum_d ^ c_in[i];
  end
`endif

  always_comb begin
    word = '0;
    for (int i = 0; i < N; i++)
      if (nxt == IW'(i)) word = 32'(cap[i]);
`ifdef WB_CHECKSUM_EN
    if (nxt == IW'(N)) word = 32'(csum);
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trig) state_d = CAPTURE;
      CAPTURE: state_d = WRITE;
      WRITE:   if (accept && idx == LAST) state_d = FINISH;
      FINISH:  if (!done_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_in;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= '0;
      base           <= '0;
      avm_address    <= '0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      for (int i = 0; i < N; i++)
        cap[i] <= '0;
`ifdef WB_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      if (state_q == IDLE && trig) begin
        for (int i = 0; i < N; i++)
          cap[i] <= c_in[i];
        base <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
        idx  <= '0;
`ifdef WB_CHECKSUM_EN
        csum <= csum_d;
`endif
      end
      if (state_q == CAPTURE) begin
        avm_address    <= base;
        avm_writedata  <= 32'(cap[0]);
        avm_write      <= 1'b1;
        avm_byteenable <= 4'hF;
      end
      if (accept) begin
        if (idx == LAST) begin
          avm_write      <= 1'b0;
          avm_byteenable <= 4'h0;
        end else begin
          idx           <= nxt;
          avm_address   <= base + (ADDR_WIDTH'(nxt) << 2);
          avm_writedata <= word;
        end
      end
    end
  end

endmodule

// File: tb/tb_mvm_result_writeback.sv
// Randomized bench for mvm_result_writeback against an address/data list model.
// Build with +define+WB_CHECKSUM_EN to cover the checksum word.
module tb_mvm_result_writeback;

  localparam int N = 8;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n;
  logic        done_in;
  logic [23:0] c_in [N];
  logic [31:0] base_addr;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        wb_done;
  logic        busy;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int stalls [N+1];

  mvm_result_writeback dut (
    .CLOCK_50        (CLOCK_50),
    .rst_n           (rst_n),
    .done_in         (done_in),
    .c_in            (c_in),
    .base_addr       (base_addr),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .wb_done         (wb_done),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_stalls();
    foreach (stalls[i]) stalls[i] = 0;
  endtask

  task automatic rand_cin();
    foreach (c_in[i]) c_in[i] = 24'($urandom);
  endtask

  task automatic chk_reset_vals();
    check("rst_write", avm_write, 0);
    check("rst_addr", avm_address, 0);
    check("rst_data", avm_writedata, 0);
    check("rst_be", avm_byteenable, 0);
    check("rst_done", wb_done, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
  endtask

  // Called at a negedge; raises done_in and follows the burst to re-arm.
  task automatic burst(input logic [31:0] b, input bit snap,
                       input int abort_after);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] ba, x, ha, hd;
    int acc, cyc, first, sc, total, nx;
    bit stalled, wr;
    ba = b & 32'hFFFF_FFFC;
    x = 0;
    for (int i = 0; i < N; i++) begin
      ea.push_back(ba + 32'(4 * i));
      ed.push_back(32'(c_in[i]));
      x ^= 32'(c_in[i]);
    end
`ifdef WB_CHECKSUM_EN
    ea.push_back(ba + 32'(4 * N));
    ed.push_back(x);
`endif
    total = 0;
    for (int i = 0; i < ea.size(); i++) total += stalls[i];
    base_addr = b;
    done_in = 1'b1;
    avm_waitrequest = 1'b0;
    acc = 0; cyc = 0; first = -1; sc = 0; stalled = 0;
    while (acc < ea.size() && cyc < 300) begin
      @(negedge CLOCK_50);
      cyc++;
      if (snap && cyc == 1) foreach (c_in[i]) c_in[i] = 24'hFFFFFF;
      if (avm_write) begin
        if (first < 0) begin
          first = cyc;
          check("latency", cyc, 2);
        end
        check("busy", busy, 1);
        if (stalled) begin
          check("hold_addr", avm_address, ha);
          check("hold_data", avm_writedata, hd);
        end
        wr = (sc < stalls[acc]);
        avm_waitrequest = wr;
        if (wr) begin
          sc++; stalled = 1;
          ha = avm_address; hd = avm_writedata;
        end else begin
          check("addr", avm_address, ea[acc]);
          check("data", avm_writedata, ed[acc]);
          check("be", avm_byteenable, 4'hF);
          check("done_early", wb_done, 0);
          sc = 0; stalled = 0; acc++;
          if (acc == abort_after) begin
            @(posedge CLOCK_50);
            #2 rst_n = 1'b0;
            #1 chk_reset_vals();
            return;
          end
        end
      end else begin
        avm_waitrequest = 1'($urandom_range(0, 1));
      end
    end
    check("accepts", acc, ea.size());
    check("span", cyc - first, ea.size() - 1 + total);
    @(negedge CLOCK_50);
    avm_waitrequest = 1'b0;
    check("wb_done", wb_done, 1);
    check("write_off", avm_write, 0);
    check("be_off", avm_byteenable, 0);
    check("busy_off", busy, 0);
    nx = 0;
    repeat (6) begin
      @(negedge CLOCK_50);
      if (avm_write) nx++;
    end
    check("no_rerun", nx, 0);
    check("fin_state", dbg_state, 3);
    check("fin_done", wb_done, 1);
    done_in = 1'b0;
    @(negedge CLOCK_50);
    check("rearm_done", wb_done, 0);
    check("rearm_state", dbg_state, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    done_in = 1'b0;
    base_addr = '0;
    avm_waitrequest = 1'b0;
    foreach (c_in[i]) c_in[i] = '0;
    clr_stalls();
    #25;
    chk_reset_vals();
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(negedge CLOCK_50);

    foreach (c_in[i]) c_in[i] = 24'(24'h000100 * (i + 1));
    burst(32'h0000_1000, 0, 0);

    rand_cin();
    stalls[0] = 3;
    stalls[4] = 5;
    burst(32'h0000_3000, 0, 0);
    clr_stalls();

    rand_cin();
    burst(32'h0000_4000, 1, 0);

    rand_cin();
    burst(32'h0000_5000, 0, 3);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    burst(32'h0000_5000, 0, 0);

    foreach (c_in[i]) c_in[i] = 24'(i + 1);
    burst(32'h0000_2000, 0, 0);

    rand_cin();
    burst(32'hFFFF_FFF0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      rand_cin();
      foreach (stalls[i]) stalls[i] = $urandom_range(0, 3);
      burst($urandom, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mvm_result_writeback.md
Name: mvm_result_writeback

Overview:
- Drains the eight 24-bit row results of the matrix-vector multiplier to memory over an Avalon-MM master write interface.
- This is the write-back end of the MVM datapath; the Avalon loader fills the operand FIFOs at the front end.
- Triggered by a rising edge of the multiplier's done level.
- Snapshots all results into a local capture bank, then issues one 32-bit write per row at consecutive word addresses, honouring waitrequest.

Parameters:
- N, 8, number of result rows captured and written.
- RES_WIDTH, 24, width of each result element.
- ADDR_WIDTH, 32, Avalon byte-address width.

Ports:
- CLOCK_50  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- done_in  in  1  multiplier done level; held high until the multiplier is reset
- c_in  in  N x RES_WIDTH  unpacked result array, index 0 = row 0
- base_addr  in  ADDR_WIDTH  destination byte address, word aligned; sampled at capture
- avm_address  out  ADDR_WIDTH  write byte address
- avm_write  out  1  write request
- avm_writedata  out  32  zero-extended result word
- avm_byteenable  out  4  always 4'hF while avm_write=1, else 0
- avm_waitrequest  in  1  slave stall
- wb_done  out  1  all writes accepted
- busy  out  1  high in CAPTURE/WRITE
- dbg_state  out  2  current state encoding

Behaviour:
- Reset values: state IDLE; avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0; wb_done=0; busy=0; idx=0; done_q=0; capture bank cleared.
- Edge detect: done_q <= done_in every cycle. trig = done_in & ~done_q.
- States: IDLE=0, CAPTURE=1, WRITE=2, FINISH=3.
- IDLE:
  - On trig, register all c_in[0..N-1] and base_addr (aligned: low 2 bits forced 0).
  - Set idx=0 and go to CAPTURE.
  - Later changes on c_in are ignored.
- CAPTURE: one cycle.
  - Present the first request: avm_address=base, avm_writedata={8'h0,cap[0]}, avm_write=1.
  - Go to WRITE.
- WRITE:
  - A transfer is accepted in a cycle where avm_write=1 and avm_waitrequest=0.
  - While waitrequest=1, address, data, byteenable and write hold stable.
  - On accept with idx<N-1: idx++, and next cycle present address base+4*(idx+1) with data cap[idx+1]. Requests are back-to-back; no bubble is required.
  - On accept with idx=N-1: deassert avm_write next cycle and go to FINISH.
- FINISH:
  - wb_done=1 held.
  - When done_in falls (multiplier reset or cleared), clear wb_done and return to IDLE, re-armed.
- Minimum latency:
  - trig to first avm_write=1 is 2 cycles (trig registered in IDLE, request driven from CAPTURE).
  - With waitrequest tied low, N writes occupy N consecutive cycles.
  - wb_done rises 1 cycle after the last accept.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is flagged.
- trig during CAPTURE/WRITE/FINISH is ignored; no recapture.
- done_in already high coming out of reset: done_q resets to 0, so this counts as a rising edge and triggers capture.
- Asynchronous reset mid-burst: avm_write drops immediately, all state returns to reset values, and a partial burst is abandoned.
- busy = (state==CAPTURE)|(state==WRITE).

Optional Feature:
- Macro WB_CHECKSUM_EN.
- When defined:
  - After the Nth accept, issue one extra write at base+4*N carrying {8'h0, XOR of cap[0..N-1]}, then go to FINISH.
  - The checksum is computed at capture.
  - wb_done rises 1 cycle after the checksum write is accepted.
- When undefined: exactly N writes per burst, and no XOR logic is synthesized.

Test Plan:
- Base burst:
  - Stimulus: base_addr=32'h0000_1000, c_in[i]=24'h000100*(i+1), waitrequest=0, raise done_in.
  - Response: 8 writes at 0x1000..0x101C with data 0x00000100..0x00000800 on consecutive cycles, byteenable=F; wb_done 1 cycle after the last write.
- Backpressure:
  - Stimulus: waitrequest high 3 cycles on write 0 and 5 cycles on write 4.
  - Response: address/data held stable through each stall; 8 accepts total, with no duplicate or skipped index.
- Snapshot isolation:
  - Stimulus: change c_in to all 24'hFFFFFF one cycle after the done_in rise.
  - Response: written data still equals the values present at the trigger.
- Reset mid-burst:
  - Stimulus: assert rst_n low after the 3rd accept.
  - Response: avm_write=0 asynchronously and all outputs at reset values. On release with done_in high, a fresh full 8-write burst starts.
- Re-arm:
  - Stimulus: drop done_in in FINISH, then raise it again with new c_in.
  - Response: wb_done clears, and a second burst writes the new values. A done_in held high without falling produces no second burst.
- Checksum (WB_CHECKSUM_EN):
  - Stimulus: c_in = {24'h000001, 24'h000002, ..., 24'h000008}, base 0x2000.
  - Response: 9th write at 0x2020 with data 0x00000008 (the XOR of 1..8), and wb_done only after it is accepted.
